// File: rtl/pkg_alu.sv
// Shared types for the registered CPU ALU: opcodes, shift modes, flag positions,
// and the request/response structs passed between the operand mux and output regs.
package pkg_alu;

  localparam int ALU_W = 32;

  // Flag bit positions inside flags_in / flags_out
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_ADC = 4'd1,
    OP_SUB = 4'd2,
    OP_SBC = 4'd3,
    OP_RSB = 4'd4,
    OP_AND = 4'd5,
    OP_ORR = 4'd6,
    OP_XOR = 4'd7,
    OP_BIC = 4'd8,
    OP_LSL = 4'd9,
    OP_LSR = 4'd10,
    OP_ASR = 4'd11,
    OP_ROR = 4'd12,
    OP_MUL = 4'd13,
    OP_MOV = 4'd14,
    OP_MVN = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'd0,
    SH_LSR = 2'd1,
    SH_ASR = 2'd2,
    SH_ROR = 2'd3
  } sh_mode_e;

  typedef struct packed {
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    alu_op_e          oper;
    logic [3:0]       flags;
  } alu_req_t;

  typedef struct packed {
    logic [ALU_W-1:0] result;
    logic [3:0]       flags;
  } alu_rsp_t;

  // Shift opcodes 9..12 are consecutive, so the mode is just the offset from LSL
  function automatic sh_mode_e op_to_shmode(input alu_op_e op);
    logic [3:0] d;
    d = op - OP_LSL;
    return sh_mode_e'(d[1:0]);
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational 32-bit barrel shifter (LSL/LSR/ASR/ROR) with carry-out of the
// last bit shifted out and a flag for a zero shift amount.
module alu_shifter
  import pkg_alu::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [4:0]       amt,
  input  sh_mode_e         mode,
  output logic [ALU_W-1:0] res,
  output logic             cout,
  output logic             shift_zero
);

  logic [ALU_W:0]     ext_l;
  logic [ALU_W:0]     ext_r;
  logic [2*ALU_W-1:0] rot;

  // Shift one bit wider than the data so the outgoing bit lands in the spare slot
  always_comb begin
    ext_l      = {1'b0, a} << amt;
    ext_r      = '0;
    rot        = {a, a} >> amt;
    res        = a;
    cout       = 1'b0;
    shift_zero = (amt == 5'd0);
    unique case (mode)
      SH_LSL: begin
        res  = ext_l[ALU_W-1:0];
        cout = ext_l[ALU_W];
      end
      SH_LSR: begin
        ext_r = {a, 1'b0} >> amt;
        res   = ext_r[ALU_W:1];
        cout  = ext_r[0];
      end
      SH_ASR: begin
        ext_r = $signed({a, 1'b0}) >>> amt;
        res   = ext_r[ALU_W:1];
        cout  = ext_r[0];
      end
      SH_ROR: begin
        res  = rot[ALU_W-1:0];
        cout = rot[ALU_W-1];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_alu.sv
// Registered 32-bit integer ALU, one-cycle latency, one op per cycle.
// Optional multiplier for opcode 13 enabled by defining CPU_ALU_MUL_EN;
// without it opcode 13 yields 0 and passes the flags through untouched.
module cpu_alu
  import pkg_alu::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic [3:0]       oper,
  input  logic [3:0]       flags_in,
  output logic             out_valid,
  output logic [ALU_W-1:0] result,
  output logic [3:0]       flags_out
);

  alu_req_t         req;
  alu_rsp_t         nxt;
  logic [ALU_W-1:0] add_x, add_y, sh_res;
  logic             add_ci, sh_c, sh_zero;
  logic [ALU_W:0]   sum;

  assign req = '{a: a, b: b, oper: alu_op_e'(oper), flags: flags_in};

  alu_shifter u_shift (
    .a          (req.a),
    .amt        (req.b[4:0]),
    .mode       (op_to_shmode(req.oper)),
    .res        (sh_res),
    .cout       (sh_c),
    .shift_zero (sh_zero)
  );

  // Operand select for the single 33-bit adder shared by all arithmetic opcodes
  always_comb begin
    add_x  = req.a;
    add_y  = req.b;
    add_ci = 1'b0;
    unique case (req.oper)
      OP_ADC:  add_ci = req.flags[FLAG_C];
      OP_SUB:  begin add_y = ~req.b; add_ci = 1'b1; end
      OP_SBC:  begin add_y = ~req.b; add_ci = req.flags[FLAG_C]; end
      OP_RSB:  begin add_x = req.b; add_y = ~req.a; add_ci = 1'b1; end
      default: ;
    endcase
    sum = {1'b0, add_x} + {1'b0, add_y} + {{ALU_W{1'b0}}, add_ci};
  end

`ifdef CPU_ALU_MUL_EN
  logic [ALU_W-1:0] mul_lo;
  assign mul_lo = req.a * req.b;
`endif

  // Result mux and flag update; C/V default to pass-through
  always_comb begin
    nxt.result = '0;
    nxt.flags  = req.flags;
    unique case (req.oper)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_RSB: begin
        nxt.result        = sum[ALU_W-1:0];
        nxt.flags[FLAG_C] = sum[ALU_W];
        nxt.flags[FLAG_V] = (add_x[ALU_W-1] == add_y[ALU_W-1]) &&
                            (sum[ALU_W-1] != add_x[ALU_W-1]);
      end
      OP_AND: nxt.result = req.a & req.b;
      OP_ORR: nxt.result = req.a | req.b;
      OP_XOR: nxt.result = req.a ^ req.b;
      OP_BIC: nxt.result = req.a & ~req.b;
      OP_LSL, OP_LSR, OP_ASR, OP_ROR: begin
        nxt.result = sh_res;
        if (!sh_zero) nxt.flags[FLAG_C] = sh_c;
      end
`ifdef CPU_ALU_MUL_EN
      OP_MUL: nxt.result = mul_lo;
`else
      OP_MUL: nxt.result = '0;
`endif
      OP_MOV: nxt.result = req.b;
      OP_MVN: nxt.result = ~req.b;
      default: ;
    endcase
    nxt.flags[FLAG_Z] = (nxt.result == '0);
    nxt.flags[FLAG_N] = nxt.result[ALU_W-1];
`ifndef CPU_ALU_MUL_EN
    // Missing multiplier: leave every flag exactly as it came in
    if (req.oper == OP_MUL) nxt.flags = req.flags;
`endif
  end

  // Output registers; result/flags only update on a launched op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags_out <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result    <= nxt.result;
        flags_out <= nxt.flags;
      end
    end
  end

endmodule

// File: tb/tb_cpu_alu.sv
// Self-checking bench for cpu_alu: directed corner cases, randomized ops against
// an arithmetic reference model, back-to-back issue and mid-stream reset.
module tb_cpu_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [3:0]  oper = '0, flags_in = '0;
  logic        out_valid;
  logic [31:0] result;
  logic [3:0]  flags_out;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  cpu_alu dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .oper(oper), .flags_in(flags_in), .out_valid(out_valid),
    .result(result), .flags_out(flags_out)
  );

  function automatic logic ovf(input longint s);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // Reference model from the arithmetic meaning of each opcode
  function automatic void ref_alu(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                  input logic [3:0] f, output logic [31:0] r, output logic [3:0] fo);
    longint unsigned ux = x, uy = y, u;
    longint sx = $signed(x), sy = $signed(y), s;
    int n = int'(y[4:0]);
    longint unsigned cin = f[1] ? 1 : 0;
    logic c = f[1], v = f[2];
    logic [31:0] t;
    r = '0;
    case (op)
      4'd0: begin u = ux + uy; r = u[31:0]; c = u > 64'hFFFFFFFF; v = ovf(sx + sy); end
      4'd1: begin u = ux + uy + cin; r = u[31:0]; c = u > 64'hFFFFFFFF; v = ovf(sx + sy + longint'(cin)); end
      4'd2: begin r = x - y; c = ux >= uy; v = ovf(sx - sy); end
      4'd3: begin
        u = 1 - cin;
        r = x - y - u[31:0]; c = ux >= uy + u; s = sx - sy - longint'(u); v = ovf(s);
      end
      4'd4: begin r = y - x; c = uy >= ux; v = ovf(sy - sx); end
      4'd5: r = x & y;
      4'd6: r = x | y;
      4'd7: r = x ^ y;
      4'd8: r = x & ~y;
      4'd9:  begin r = x << n; if (n != 0) c = x[32-n]; end
      4'd10: begin r = x >> n; if (n != 0) c = x[n-1]; end
      4'd11: begin r = $signed(x) >>> n; if (n != 0) c = x[n-1]; end
      4'd12: begin
        t = x;
        for (int i = 0; i < n; i++) t = {t[0], t[31:1]};
        r = t; if (n != 0) c = t[31];
      end
`ifdef CPU_ALU_MUL_EN
      4'd13: begin u = ux * uy; r = u[31:0]; end
`else
      4'd13: r = '0;
`endif
      4'd14: r = y;
      default: r = ~y;
    endcase
    fo = {r[31], v, c, r == 32'd0};
`ifndef CPU_ALU_MUL_EN
    if (op == 4'd13) fo = f;
`endif
  endfunction

  // Launch one op on the next edge and sample outputs just after it
  task automatic drive_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                          input logic [3:0] f, output logic ov, output logic [31:0] r,
                          output logic [3:0] fo);
    @(negedge clk);
    in_valid = 1'b1; oper = op; a = x; b = y; flags_in = f;
    @(posedge clk); #1;
    ov = out_valid; r = result; fo = flags_out;
  endtask

  task automatic test_reset();
    in_valid = 1'b1; oper = 4'd14; b = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || result !== 32'd0 || flags_out !== 4'd0)
      $display("FAIL reset_state: got v=%b r=%h f=%b want v=0 r=0 f=0", out_valid, result, flags_out);
    else passed++;
    @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;
  endtask

  task automatic test_directed();
    logic [3:0] op_t[13] = '{4'd0, 4'd0, 4'd2, 4'd2, 4'd3, 4'd9, 4'd11, 4'd10, 4'd12, 4'd5, 4'd13, 4'd4, 4'd1};
    logic [31:0] a_t[13] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd3, 32'd10, 32'h80000001,
                             32'h80000000, 32'h12345678, 32'h1, 32'hF0F0, 32'h10000, 32'd3, 32'hFFFFFFFF};
    logic [31:0] b_t[13] = '{32'd1, 32'd1, 32'd5, 32'd5, 32'd3, 32'd1, 32'd31, 32'h100,
                             32'd1, 32'h0F0F, 32'h10000, 32'd10, 32'd0};
    logic [3:0]  f_t[13] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                             4'b0010, 4'b0000, 4'b0110, 4'b1010, 4'b0000, 4'b0010};
    // Hand-derived expectations for the corner cases
    logic [31:0] r_t[13] = '{32'h80000000, 32'd0, 32'd0, 32'hFFFFFFFE, 32'd6, 32'd2, 32'hFFFFFFFF,
                             32'h12345678, 32'h80000000, 32'd0, 32'd0, 32'd7, 32'd0};
`ifdef CPU_ALU_MUL_EN
    logic [3:0] mul_f = 4'b0011;
`else
    logic [3:0] mul_f = 4'b1010;
`endif
    logic [3:0]  e_t[13] = '{4'b1100, 4'b0011, 4'b0011, 4'b1000, 4'b0010, 4'b0010, 4'b1000,
                             4'b0010, 4'b1010, 4'b0111, 4'b0000, 4'b0010, 4'b0011};
    logic ov; logic [31:0] r; logic [3:0] fo;
    e_t[10] = mul_f;
    for (int i = 0; i < 13; i++) begin
      drive_op(op_t[i], a_t[i], b_t[i], f_t[i], ov, r, fo);
      total++;
      if (ov !== 1'b1 || r !== r_t[i] || fo !== e_t[i])
        $display("FAIL directed_%0d op%0d: got v=%b r=%h f=%b want v=1 r=%h f=%b",
                 i, op_t[i], ov, r, fo, r_t[i], e_t[i]);
      else passed++;
    end
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic test_random();
    logic ov; logic [31:0] r, er, x, y; logic [3:0] fo, ef, op, f;
    for (int i = 0; i < 400; i++) begin
      op = 4'($urandom_range(0, 15));
      x = $urandom; y = $urandom; f = 4'($urandom);
      if (i % 4 == 0) y[4:0] = 5'd0;
      if (i % 7 == 0) x = 32'h80000000 ^ 32'($urandom_range(0, 3));
      ref_alu(op, x, y, f, er, ef);
      drive_op(op, x, y, f, ov, r, fo);
      total++;
      if (ov !== 1'b1 || r !== er || fo !== ef)
        $display("FAIL random_%0d op%0d a=%h b=%h fi=%b: got r=%h f=%b v=%b want r=%h f=%b",
                 i, op, x, y, f, r, fo, ov, er, ef);
      else passed++;
    end
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic ov; logic [31:0] r, er; logic [3:0] fo, ef;
    for (int i = 0; i < 3; i++) begin
      ref_alu(4'd0, 32'(i * 100), 32'd7, 4'b0000, er, ef);
      drive_op(4'd0, 32'(i * 100), 32'd7, 4'b0000, ov, r, fo);
      total++;
      if (ov !== 1'b1 || r !== er || fo !== ef)
        $display("FAIL b2b_%0d: got v=%b r=%h f=%b want v=1 r=%h f=%b", i, ov, r, fo, er, ef);
      else passed++;
    end
    // Idle cycle: valid drops, last result/flags hold
    @(negedge clk); in_valid = 1'b0; oper = 4'd15; b = 32'h0;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || result !== er || fo !== flags_out)
      $display("FAIL idle_hold: got v=%b r=%h f=%b want v=0 r=%h f=%b", out_valid, result, flags_out, er, ef);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic ov; logic [31:0] r; logic [3:0] fo;
    drive_op(4'd15, 32'd0, 32'd0, 4'b0000, ov, r, fo);   // result 0xFFFFFFFF, N set
    drive_op(4'd14, 32'd0, 32'h55, 4'b0000, ov, r, fo);
    drive_op(4'd15, 32'd0, 32'h1, 4'b0000, ov, r, fo);
    total++;
    if (ov !== 1'b1 || r !== 32'hFFFFFFFE)
      $display("FAIL mid_pre: got v=%b r=%h want v=1 r=fffffffe", ov, r);
    else passed++;
    // Reset lands between edges while in_valid stays high
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || result !== 32'd0 || flags_out !== 4'd0)
      $display("FAIL mid_reset_async: got v=%b r=%h f=%b want 0/0/0", out_valid, result, flags_out);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || result !== 32'd0)
      $display("FAIL mid_reset_discard: got v=%b r=%h want v=0 r=0", out_valid, result);
    else passed++;
    @(negedge clk); rst_n = 1'b1; oper = 4'd14; b = 32'h77;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b1 || result !== 32'h77)
      $display("FAIL post_reset: got v=%b r=%h want v=1 r=00000077", out_valid, result);
    else passed++;
    @(negedge clk); in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, passed=%0d total=%0d", passed, total);
    $fatal(1);
  end

endmodule
